// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between the VGA display stream and a
// simple CPU request/ack port. The display always wins while the raster is
// inside the active window; the CPU is served only in blanking/border time.
//
// Ports
//   clk, reset_n            pixel clock, asynchronous active-low reset
//   counter_x/counter_y     raster position from the VGA timing generator
//   offset                  framebuffer base address, latched once per frame
//   cpu_req/we/addr/wdata   CPU request, held stable until cpu_ack
//   cpu_ack/rdata/err       one-cycle completion, read data, out-of-range flag
//   mem_addr/we/wdata       registered single-port RAM controls
//   mem_rdata               RAM read data, one cycle after mem_addr
//   color                   grayscale pixel (0 outside the window)
//   frame_start             one-cycle pulse after raster position (0,0)
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int WIN_X0   = 142,
    parameter int WIN_Y0   = 35,
    parameter int WIN_W    = 300,
    parameter int WIN_H    = 300,
    parameter int FB_WORDS = 90000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    input  logic [17:0] offset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    output logic [17:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  color,
    output logic        frame_start
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DISP    = 3'd1,
        CPU_WR  = 3'd2,
        CPU_RD  = 3'd3,
        CPU_RSP = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        in_win;
    logic        cpu_bad;
    logic [17:0] off_lat;
    logic [17:0] disp_addr;

    // Read-source tags: p1 travels with mem_addr, p2 lines up with mem_rdata.
    logic        rd_disp_p1, rd_disp_p2;
    logic        rd_cpu_p1,  rd_cpu_p2;

    logic [17:0] mem_addr_nxt;
    logic        mem_we_nxt;
    logic [7:0]  mem_wdata_nxt;
    logic        rd_disp_nxt, rd_cpu_nxt;
    logic        ack_nxt, err_nxt;

    // Stage p0: raster decode and address generation
    always_comb begin
        in_win = ({1'b0, counter_x} >= 11'(WIN_X0))
              && ({1'b0, counter_x} <  11'(WIN_X0 + WIN_W))
              && ({1'b0, counter_y} >= 11'(WIN_Y0))
              && ({1'b0, counter_y} <  11'(WIN_Y0 + WIN_H));
    end

    // The relative terms are only meaningful inside the window; the sum wraps mod 2^18.
    always_comb begin
        disp_addr = off_lat
                  + (18'(counter_y - 10'(WIN_Y0)) * 18'(WIN_W))
                  + 18'(counter_x - 10'(WIN_X0));
    end

    always_comb cpu_bad = (cpu_addr >= 18'(FB_WORDS));

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a CPU grant is never issued while the raster is in the window
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_win) begin
                    state_nxt = DISP;
                end else if (cpu_req) begin
                    state_nxt = cpu_we ? CPU_WR : CPU_RD;
                end
            end
            DISP:    if (!in_win) state_nxt = IDLE;
            CPU_WR:  state_nxt = CPU_RSP;
            CPU_RD:  state_nxt = CPU_RSP;
            CPU_RSP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered memory port and CPU response.
    // Ownership of the next cycle follows in_win directly, so the display can
    // take the RAM even while the CPU response is still being delivered.
    always_comb begin
        mem_addr_nxt  = mem_addr;
        mem_we_nxt    = 1'b0;
        mem_wdata_nxt = mem_wdata;
        rd_disp_nxt   = 1'b0;
        rd_cpu_nxt    = 1'b0;
        ack_nxt       = 1'b0;
        err_nxt       = 1'b0;
        if (in_win) begin
            mem_addr_nxt = disp_addr;
            rd_disp_nxt  = 1'b1;
        end else if (state == IDLE && cpu_req && !cpu_bad) begin
            mem_addr_nxt = cpu_addr;
            mem_we_nxt   = cpu_we;
            rd_cpu_nxt   = !cpu_we;
            if (cpu_we) begin
                mem_wdata_nxt = cpu_wdata;
            end
        end
        // Out-of-range requests still pass through CPU_WR/CPU_RD but never touch the RAM.
        if (state == CPU_WR || state == CPU_RD) begin
            ack_nxt = 1'b1;
            err_nxt = cpu_bad;
        end
    end

    // Stage p1: registered RAM port, tags, CPU handshake, frame offset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            rd_disp_p1  <= 1'b0;
            rd_cpu_p1   <= 1'b0;
            rd_disp_p2  <= 1'b0;
            rd_cpu_p2   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            frame_start <= 1'b0;
            off_lat     <= '0;
        end else begin
            mem_addr    <= mem_addr_nxt;
            mem_we      <= mem_we_nxt;
            mem_wdata   <= mem_wdata_nxt;
            rd_disp_p1  <= rd_disp_nxt;
            rd_cpu_p1   <= rd_cpu_nxt;
            rd_disp_p2  <= rd_disp_p1;
            rd_cpu_p2   <= rd_cpu_p1;
            cpu_ack     <= ack_nxt;
            cpu_err     <= err_nxt;
            frame_start <= (counter_x == 10'd0) && (counter_y == 10'd0);
            // Base address only changes at frame start, so a frame never tears.
            if (frame_start) begin
                off_lat <= offset;
            end
        end
    end

    // Stage p2: route RAM read data by its source tag
    always_comb begin
        color     = rd_disp_p2 ? mem_rdata : 8'h00;
        cpu_rdata = rd_cpu_p2  ? mem_rdata : 8'h00;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int WIN_X0   = 142;
    localparam int WIN_Y0   = 35;
    localparam int WIN_W    = 300;
    localparam int WIN_H    = 300;
    localparam int FB_WORDS = 90000;
    localparam int RAM_D    = 262144;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  counter_x, counter_y;
    logic [17:0] offset;
    logic        cpu_req, cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_err;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  color;
    logic        frame_start;
    logic        ram_load;

    logic [7:0]  ram    [RAM_D];
    logic [7:0]  shadow [RAM_D];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: in_win/address of the last two raster samples,
    // and the base offset of the current frame.
    bit win_h1, win_h2;
    int addr_h1, addr_h2;
    int frame_off;

    vga_fb_arbiter #(
        .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .WIN_W(WIN_W), .WIN_H(WIN_H), .FB_WORDS(FB_WORDS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .counter_x(counter_x), .counter_y(counter_y), .offset(offset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .color(color), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ (a >> 5) ^ 32'h5A);
    endfunction

    function automatic bit ref_in_win(input int x, input int y);
        return (x >= WIN_X0) && (x < WIN_X0 + WIN_W) && (y >= WIN_Y0) && (y < WIN_Y0 + WIN_H);
    endfunction

    function automatic int ref_addr(input int x, input int y, input int off);
        return (off + (y - WIN_Y0) * WIN_W + (x - WIN_X0)) & 32'h3FFFF;
    endfunction

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < RAM_D; i++) ram[i] <= pat(i);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        win_h2  = win_h1;
        addr_h2 = addr_h1;
        win_h1  = ref_in_win(int'(counter_x), int'(counter_y));
        addr_h1 = ref_addr(int'(counter_x), int'(counter_y), frame_off);
        if (counter_x == 10'd0 && counter_y == 10'd0) frame_off = int'(offset);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ram_load = 1'b1;
        counter_x = 10'd0; counter_y = 10'd0; offset = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        win_h1 = 0; win_h2 = 0; addr_h1 = 0; addr_h2 = 0; frame_off = 0;
        repeat (3) @(posedge clk);
        #1;
        ram_load = 1'b0;
        counter_x = 10'd300; counter_y = 10'd400;
        @(posedge clk);
        #1;
        n_cmp++; if (mem_addr !== 18'd0)   begin n_fail++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_we: got %0b expected 0", mem_we); end
        n_cmp++; if (mem_wdata !== 8'd0)   begin n_fail++; $display("FAIL rst_mem_wdata: got %0h expected 0", mem_wdata); end
        n_cmp++; if (color !== 8'd0)       begin n_fail++; $display("FAIL rst_color: got %0h expected 0", color); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %0b expected 0", frame_start); end
        n_cmp++; if (cpu_ack !== 1'b0)     begin n_fail++; $display("FAIL rst_cpu_ack: got %0b expected 0", cpu_ack); end
        n_cmp++; if (cpu_err !== 1'b0)     begin n_fail++; $display("FAIL rst_cpu_err: got %0b expected 0", cpu_err); end
        n_cmp++; if (cpu_rdata !== 8'd0)   begin n_fail++; $display("FAIL rst_cpu_rdata: got %0h expected 0", cpu_rdata); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_frame_start(input logic [17:0] off);
        offset = off;
        counter_x = 10'd0; counter_y = 10'd0;
        tick();
        n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL frame_start_pulse: got %0b expected 1", frame_start); end
        counter_x = 10'd1;
        tick();
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: got %0b expected 0", frame_start); end
        counter_x = 10'd2;
        tick();
        tick();
    endtask

    task automatic test_display_span(input int y, input int x0, input int x1);
        logic [7:0] exp_c;
        for (int x = x0; x <= x1; x++) begin
            counter_x = 10'(x); counter_y = 10'(y);
            tick();
            if (win_h1) begin
                n_cmp++;
                if (mem_addr !== 18'(addr_h1) || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL disp_addr x=%0d y=%0d: got addr %0d we %0b expected addr %0d we 0", x, y, mem_addr, mem_we, addr_h1);
                end
            end
            exp_c = win_h2 ? shadow[addr_h2] : 8'h00;
            n_cmp++;
            if (color !== exp_c) begin
                n_fail++;
                $display("FAIL disp_color x=%0d y=%0d: got %0h expected %0h", x, y, color, exp_c);
            end
        end
    endtask

    task automatic test_display_line();
        test_display_span(35, WIN_X0 - 2, WIN_X0 + WIN_W - 1);
        test_display_span(35, WIN_X0 + WIN_W, WIN_X0 + WIN_W + 3);
    endtask

    task automatic test_cpu_txn(input bit we, input int addr, input logic [7:0] data);
        bit bad;
        logic [7:0] exp_r;
        bad = (addr >= FB_WORDS);
        counter_x = 10'($urandom_range(10, 110)); counter_y = 10'($urandom_range(1, 34));
        cpu_req = 1'b1; cpu_we = we; cpu_addr = 18'(addr); cpu_wdata = data;
        tick();
        n_cmp++;
        if (mem_we !== (we && !bad) || cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL txn_issue a=%0d: got we %0b ack %0b expected we %0b ack 0", addr, mem_we, cpu_ack, we && !bad);
        end
        if (!bad) begin
            n_cmp++;
            if (mem_addr !== 18'(addr)) begin n_fail++; $display("FAIL txn_addr: got %0d expected %0d", mem_addr, addr); end
            if (we) begin
                n_cmp++;
                if (mem_wdata !== data) begin n_fail++; $display("FAIL txn_wdata: got %0h expected %0h", mem_wdata, data); end
            end
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_err !== bad || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL txn_ack a=%0d: got ack %0b err %0b we %0b expected ack 1 err %0b we 0", addr, cpu_ack, cpu_err, mem_we, bad);
        end
        if (!we || bad) begin
            exp_r = bad ? 8'h00 : shadow[addr];
            n_cmp++;
            if (cpu_rdata !== exp_r) begin n_fail++; $display("FAIL txn_rdata a=%0d: got %0h expected %0h", addr, cpu_rdata, exp_r); end
        end
        cpu_req = 1'b0;
        if (we && !bad) shadow[addr] = data;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL txn_single_ack: got %0b expected 0", cpu_ack); end
    endtask

    task automatic test_cpu_write_read();
        test_cpu_txn(1'b1, 5, 8'hA5);
        test_cpu_txn(1'b0, 5, 8'h00);
        n_cmp++;
        if (shadow[5] !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_model: got %0h expected a5", shadow[5]); end
    endtask

    task automatic test_cpu_read_near_window();
        int nack = 0, ack_x = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'd5;
        for (int x = 140; x <= 150; x++) begin
            counter_x = 10'(x); counter_y = 10'd50;
            tick();
            if (win_h1) begin
                n_cmp++;
                if (mem_addr !== 18'(addr_h1) || mem_we !== 1'b0) begin
                    n_fail++; $display("FAIL near_disp_addr x=%0d: got %0d expected %0d", x, mem_addr, addr_h1);
                end
            end
            if (cpu_ack === 1'b1) begin
                nack++; ack_x = x; cpu_req = 1'b0;
                n_cmp++;
                if (cpu_rdata !== shadow[5]) begin n_fail++; $display("FAIL near_rdata: got %0h expected %0h", cpu_rdata, shadow[5]); end
            end
        end
        n_cmp++; if (nack != 1)   begin n_fail++; $display("FAIL near_ack_count: got %0d expected 1", nack); end
        n_cmp++; if (ack_x != 141) begin n_fail++; $display("FAIL near_ack_cycle: got %0d expected 141", ack_x); end
        cpu_req = 1'b0;
        test_display_span(50, 151, WIN_X0 + WIN_W + 3);
    endtask

    task automatic test_cpu_wait_window();
        int nwe = 0, first_we_x = -1;
        bit got = 0;
        logic [7:0] d;
        d = 8'($urandom);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'd77; cpu_wdata = d;
        for (int x = 200; x < 470 && !got; x++) begin
            counter_x = 10'(x); counter_y = 10'd50;
            tick();
            if (win_h1) begin
                n_cmp++;
                if (mem_we !== 1'b0 || mem_addr !== 18'(addr_h1) || cpu_ack !== 1'b0) begin
                    n_fail++; $display("FAIL wait_disp x=%0d: got we %0b addr %0d ack %0b expected we 0 addr %0d ack 0", x, mem_we, mem_addr, cpu_ack, addr_h1);
                end
            end
            if (mem_we === 1'b1) begin nwe++; if (first_we_x < 0) first_we_x = x; end
            if (cpu_ack === 1'b1) begin got = 1; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0;
        n_cmp++; if (!got)             begin n_fail++; $display("FAIL wait_ack_timeout: got no ack expected ack"); end
        n_cmp++; if (nwe != 1)         begin n_fail++; $display("FAIL wait_we_count: got %0d expected 1", nwe); end
        n_cmp++; if (first_we_x < 442) begin n_fail++; $display("FAIL wait_we_early: got x %0d expected >= 442", first_we_x); end
        if (got) shadow[77] = d;
        test_display_span(50, 460, 463);
        test_cpu_txn(1'b0, 77, 8'h00);
    endtask

    task automatic test_cpu_error();
        test_cpu_txn(1'b1, FB_WORDS, 8'hFF);
        test_cpu_txn(1'b0, FB_WORDS + 5, 8'h00);
        test_cpu_txn(1'b0, RAM_D - 1, 8'h00);
    endtask

    task automatic test_offset_latch();
        test_frame_start(18'd0);
        test_display_span(35, 142, 149);
        offset = 18'd1000;
        test_display_span(35, 442, 443);
        counter_x = 10'd142; counter_y = 10'd36;
        tick();
        n_cmp++; if (mem_addr !== 18'd300) begin n_fail++; $display("FAIL offset_hold: got %0d expected 300", mem_addr); end
        test_display_span(36, 143, 146);
        test_display_span(36, 442, 444);
        test_frame_start(18'd1000);
        counter_x = 10'd142; counter_y = 10'd35;
        tick();
        n_cmp++; if (mem_addr !== 18'd1000) begin n_fail++; $display("FAIL offset_new_frame: got %0d expected 1000", mem_addr); end
        test_display_span(35, 143, 147);
        test_display_span(35, 442, 444);
    endtask

    task automatic test_back_to_back();
        int nack = 0, nwe = 0, a;
        logic [7:0] d;
        a = $urandom_range(0, FB_WORDS - 1); d = 8'($urandom);
        counter_x = 10'd20; counter_y = 10'd20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'(a); cpu_wdata = d;
        repeat (6) begin
            tick();
            if (mem_we === 1'b1) nwe++;
            if (cpu_ack === 1'b1) nack++;
        end
        cpu_req = 1'b0;
        shadow[a] = d;
        tick();
        n_cmp++; if (nack != 2)        begin n_fail++; $display("FAIL b2b_ack_count: got %0d expected 2", nack); end
        n_cmp++; if (nwe != 2)         begin n_fail++; $display("FAIL b2b_we_count: got %0d expected 2", nwe); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got %0b expected 0", cpu_ack); end
        tick();
    endtask

    task automatic test_reset_mid_txn();
        int nwe = 0, a;
        bit got = 0;
        logic [7:0] d;
        a = $urandom_range(0, FB_WORDS - 1); d = 8'($urandom);
        counter_x = 10'd20; counter_y = 10'd20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'(a); cpu_wdata = d;
        tick();
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_before: got %0b expected 1", mem_we); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || cpu_ack !== 1'b0 || mem_addr !== 18'd0) begin
            n_fail++; $display("FAIL mid_async_clear: got we %0b ack %0b addr %0d expected 0 0 0", mem_we, cpu_ack, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL mid_no_ack: got %0b expected 0", cpu_ack); end
        win_h1 = 0; win_h2 = 0; frame_off = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (mem_we === 1'b1) nwe++;
            if (cpu_ack === 1'b1) got = 1;
        end
        cpu_req = 1'b0;
        n_cmp++; if (!got)    begin n_fail++; $display("FAIL mid_reissue_timeout: got no ack expected ack"); end
        n_cmp++; if (nwe != 1) begin n_fail++; $display("FAIL mid_reissue_we: got %0d expected 1", nwe); end
        if (got) shadow[a] = d;
        tick();
        test_cpu_txn(1'b0, a, 8'h00);
    endtask

    task automatic test_random_cpu();
        int a, y, x0;
        bit we;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? FB_WORDS + $urandom_range(0, 200) : $urandom_range(0, FB_WORDS - 1);
            test_cpu_txn(we, a, 8'($urandom));
            y  = $urandom_range(WIN_Y0, WIN_Y0 + WIN_H - 1);
            x0 = $urandom_range(WIN_X0, WIN_X0 + WIN_W - 8);
            test_display_span(y, x0, x0 + 6);
            test_display_span(y, 450, 451);
        end
    endtask

    initial begin
        for (int i = 0; i < RAM_D; i++) shadow[i] = pat(i);
        test_reset();
        test_frame_start(18'd0);
        test_display_line();
        test_cpu_write_read();
        test_cpu_read_near_window();
        test_cpu_wait_window();
        test_cpu_error();
        test_offset_latch();
        test_back_to_back();
        test_random_cpu();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIN_X0, 142, first active window column (counter_x).
- WIN_Y0, 35, first active window row (counter_y).
- WIN_W, 300, window width in pixels.
- WIN_H, 300, window height in lines.
- FB_WORDS, 90000, framebuffer depth.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
- clk  in  1  pixel clock; one clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- counter_x  in  10  horizontal counter from the VGA generator.
- counter_y  in  10  vertical counter from the VGA generator.
- offset  in  18  framebuffer base address.
- cpu_req  in  1  CPU request; held with addr/we/wdata until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  18  CPU word address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid with cpu_ack.
- cpu_err  out  1  out-of-range flag, valid with cpu_ack.
- mem_addr  out  18  single-port RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  8  RAM write data (registered).
- mem_rdata  in  8  RAM read data, 1-cycle latency after mem_addr.
- color  out  8  grayscale pixel to the VGA generator.
- frame_start  out  1  one-cycle pulse when counter_x==0 and counter_y==0.

Function
REQ-003 in_win SHALL be true iff WIN_X0<=counter_x<WIN_X0+WIN_W and WIN_Y0<=counter_y<WIN_Y0+WIN_H.
REQ-004 Memory ownership for cycle N+1 SHALL be decided from in_win at cycle N; the display owns the memory whenever in_win is true.
REQ-005 Display address SHALL be off_lat + (counter_y-WIN_Y0)*WIN_W + (counter_x-WIN_X0), truncated mod 2^18.
REQ-006 off_lat SHALL load from offset only on frame_start cycles, so there is no mid-frame tearing.
REQ-007 color SHALL equal mem_rdata exactly 2 cycles after the counter sample that is in_win, and 8'h00 otherwise.
REQ-008 The FSM SHALL have states IDLE, DISP, CPU_WR, CPU_RD, CPU_RSP.
- IDLE->DISP when in_win.
- IDLE->CPU_WR/CPU_RD when cpu_req and !in_win.
- DISP->IDLE when !in_win.
- CPU_WR->CPU_RSP.
- CPU_RD->CPU_RSP.
- CPU_RSP->IDLE.
REQ-009 CPU_WR SHALL drive mem_we=1 for exactly one cycle; cpu_ack SHALL pulse in CPU_RSP.
REQ-010 CPU_RD SHALL drive mem_addr=cpu_addr with mem_we=0; cpu_rdata SHALL be captured from mem_rdata in CPU_RSP, together with cpu_ack.
REQ-011 A read-source tag SHALL travel with each read, so that mem_rdata is routed to cpu_rdata or color even when a CPU read is in flight as in_win rises.
REQ-012 If in_win rises while in CPU_RSP, the display SHALL take the memory the next cycle and the CPU response SHALL still complete.
REQ-013 A new CPU grant SHALL NOT be issued in the cycle in which in_win is true, so the display never misses a pixel.
REQ-014 If cpu_addr>=FB_WORDS, the block SHALL suppress mem_we and RAM access, and pulse cpu_ack with cpu_err=1 and cpu_rdata=0 one cycle after acceptance.
REQ-015 cpu_req with identical fields held after cpu_ack SHALL be treated as a new request.
REQ-016 The CPU SHALL wait indefinitely during in_win; there is no timeout.
REQ-017 mem_we SHALL never be 1 while the display owns the memory.

Reset
REQ-018 On reset_n=0 the block SHALL immediately enter IDLE with all of the following at 0:
- cpu_ack, cpu_err, cpu_rdata.
- mem_addr, mem_we, mem_wdata.
- color, frame_start, off_lat.
- the read-source tag.
REQ-019 When reset asserts mid-transaction, the block SHALL drop the transaction with no ack; the CPU re-issues it.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- counter_y=35, counter_x=142..441 with offset=0 -> mem_addr 0..299 in consecutive cycles; color=mem_rdata 2 cycles later.
- CPU write addr=5, data=8'hA5 at counter_x=10 -> mem_we=1 once; cpu_ack after 2 cycles; CPU read addr=5 then returns 8'hA5.
- CPU read issued at counter_x=140, counter_y=50 -> completes; display reads at 142 unaffected; cpu_rdata is not corrupted by the display stream.
- cpu_req at counter_x=200 inside the window -> no mem_we until counter_x=442; then ack.
- cpu_addr=90000 -> cpu_err=1, cpu_ack after 2 cycles, no mem_we.
- offset changed from 0 to 1000 mid-frame -> addresses unchanged until frame_start; next frame's first pixel address is 1000.
